// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode : instruction-decode stage sitting directly behind fetch.
//
// Owns the fetch PC. It captures each assembled word on i_inst_valid, splits
// it into fields, extends the immediate and queues the result. Execute drains
// the queue through a valid/ready handshake. A redirect flushes the queue and
// restarts fetch at the new PC.
//
// Parameters
//   DEPTH          decoded-instruction FIFO entries (2 or 4)
//   RESET_PC       PC after reset
// Ports
//   i_clk          clock
//   i_rst_n        synchronous active-low reset
//   i_inst         assembled word from fetch
//   i_inst_valid   one-cycle "word complete" pulse from fetch
//   o_fetch_pc     PC register, drives fetch i_pc
//   o_fetch_rst    active-high fetch restart (combinational)
//   i_redirect     execute requests a PC change
//   i_redirect_pc  redirect target
//   o_valid        FIFO head valid
//   i_ready        execute accepts the head
//   o_pc, o_opcode, o_rd, o_rs1, o_rs2, o_imm, o_illegal : head fields
//
// Build option
//   DECODE_ILLEGAL_HALT_EN  when defined, pushing opcode 6'h3F halts fetch
//                           until a redirect or reset.
// ---------------------------------------------------------------------------
module decode #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_inst,
    input  logic        i_inst_valid,
    output logic [31:0] o_fetch_pc,
    output logic        o_fetch_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [31:0] o_imm,
    output logic        o_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } entry_t;

    logic [31:0]      pc;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    entry_t           mem [DEPTH];
    entry_t           dec;
    entry_t           head;
    logic             halted;
    logic             full;
    logic             push;
    logic             pop;

    // Combinational field split and immediate extension of the incoming word.
    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.opcode  = i_inst[31:26];
        dec.rd      = i_inst[25:21];
        dec.rs1     = i_inst[20:16];
        dec.rs2     = i_inst[15:11];
        dec.illegal = (i_inst[31:26] == 6'h3F);
        unique case (i_inst[31:30])
            2'b00:   dec.imm = 32'h0;
            2'b01:   dec.imm = {{16{i_inst[15]}}, i_inst[15:0]};
            2'b10:   dec.imm = {16'h0, i_inst[15:0]};
            default: dec.imm = {{4{i_inst[25]}}, i_inst[25:0], 2'b00};
        endcase
    end

    assign full    = (count == FULL);
    assign o_valid = (count != '0);
    assign push    = i_inst_valid && !full && !i_redirect && !halted;
    assign pop     = o_valid && i_ready;

    // Every completed word restarts fetch so its next read uses the new PC.
    assign o_fetch_rst = !i_rst_n || i_inst_valid || i_redirect || full || halted;
    assign o_fetch_pc  = pc;

    // Slots keep stale data after a pop, so the head is masked when empty.
    assign head      = o_valid ? mem[rd_ptr] : '0;
    assign o_pc      = head.pc;
    assign o_opcode  = head.opcode;
    assign o_rd      = head.rd;
    assign o_rs1     = head.rs1;
    assign o_rs2     = head.rs2;
    assign o_imm     = head.imm;
    assign o_illegal = head.illegal;

`ifndef DECODE_ILLEGAL_HALT_EN
    assign halted = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_redirect) begin
            pc     <= i_rst_n ? i_redirect_pc : RESET_PC;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
`ifdef DECODE_ILLEGAL_HALT_EN
            halted <= 1'b0;
`endif
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + PTR_W'(1);
                pc          <= pc + 32'd4;
`ifdef DECODE_ILLEGAL_HALT_EN
                if (dec.illegal) begin
                    halted <= 1'b1;
                end
`endif
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule
